// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master: bus-phase encoding, PPROT bit
// positions and a width helper used to size counters and pointers.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int PROT_PRIV   = 0;
    localparam int PROT_NONSEC = 1;
    localparam int PROT_INSTR  = 2;

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/apb_rsp_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head and occupancy count.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module apb_rsp_fifo
    import apb_pkg::*;
#(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 2,
    localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CNT_FULL) || do_pop);

        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; head_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 master: turns a valid/ready command stream into APB transfers, with
// back-to-back issue, a PREADY timeout and a buffered in-order response stream.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RSP_DEPTH   = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,

    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic [2:0]          PPROT,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int RSP_W  = DATA_W + 2;
    localparam int CNT_W  = clog2_min1(RSP_DEPTH + 1);
    localparam int ROOM_W = CNT_W + 1;
    localparam int TCNT_W = clog2_min1(TIMEOUT_CYC + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) || RSP_DEPTH < 2) begin : g_bad_params
        $error("apb_master_ctrl: DATA_W must be 8/16/32 and RSP_DEPTH at least 2");
    end

    apb_state_e          state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [2:0]          pprot_q, pprot_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

    logic                in_access, timeout_hit, done, rsp_pop, room, cmd_fire;
    logic [CNT_W-1:0]    fifo_count;
    logic [RSP_W-1:0]    push_data, head_data;
    logic                head_valid;

    always_comb begin
        in_access   = (state_q == ACCESS);
        timeout_hit = (TIMEOUT_CYC != 0) && in_access && (tcnt_q == TCNT_LAST) && !PREADY;
        done        = (in_access && PREADY) || timeout_hit;
        rsp_pop     = head_valid && rsp_ready;

        // A command is taken only if its response is sure to find a FIFO slot at completion.
        room      = (ROOM_W'(fifo_count) + ROOM_W'(done)) < (ROOM_W'(RSP_DEPTH) + ROOM_W'(rsp_pop));
        cmd_ready = !PRESET && ((state_q == IDLE) || done) && room;
        cmd_fire  = cmd_valid && cmd_ready;

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_fire) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = cmd_fire ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);

        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
        if (cmd_fire) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
            pstrb_d  = cmd_write ? cmd_strb  : '0;
            pprot_d  = cmd_prot;
        end

        // SETUP always precedes ACCESS, so clearing here clears on ACCESS entry.
        tcnt_d = tcnt_q;
        if (state_q == SETUP) begin
            tcnt_d = '0;
        end else if (in_access && !PREADY) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (timeout_hit) begin
            push_data = {{DATA_W{1'b0}}, 1'b1, 1'b1};
        end else begin
            push_data = {(pwrite_q ? {DATA_W{1'b0}} : PRDATA), PSLVERR, 1'b0};
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            tcnt_q    <= tcnt_d;
        end
    end

    apb_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (PCLK),
        .rst        (PRESET),
        .push       (done),
        .push_data  (push_data),
        .pop        (rsp_pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;

    assign rsp_valid   = head_valid;
    assign rsp_rdata   = head_data[RSP_W-1:2];
    assign rsp_err     = head_data[1];
    assign rsp_timeout = head_data[0];

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: directed latency/ordering/backpressure/reset
// scenarios followed by randomized traffic against a reactive APB slave model.
module tb_apb_master_ctrl;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        bit          err;
        logic [31:0] rdata;
    } xfer_t;

    logic          PCLK, PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_xfer = 0;
    int rr_mode = 0;   // 0: rsp_ready high, 1: random, 2: driven by the test
    xfer_t       bus_q[$];
    logic [33:0] exp_q[$];

    apb_master_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(2), .TIMEOUT_CYC(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Response expected from the rules: timeout wins, writes return zero data.
    function automatic logic [33:0] model(input xfer_t x);
        if (x.waits >= TO) return {32'h0, 1'b1, 1'b1};
        return {(x.write ? 32'h0 : x.rdata), x.err, 1'b0};
    endfunction

    function automatic xfer_t rand_x();
        xfer_t x;
        x.write = 1'($urandom_range(0, 1));
        x.addr  = $urandom;
        x.wdata = $urandom;
        x.strb  = 4'($urandom_range(0, 15));
        x.prot  = 3'($urandom_range(0, 7));
        x.waits = $urandom_range(0, 5);
        x.err   = ($urandom_range(0, 3) == 0);
        x.rdata = $urandom;
        return x;
    endfunction

    function automatic xfer_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                 input int w, input bit e, input logic [31:0] rd);
        xfer_t x;
        x.write = wr; x.addr = a; x.wdata = d; x.strb = 4'hF;
        x.prot  = 3'(1 << PROT_NONSEC);
        x.waits = w; x.err = e; x.rdata = rd;
        return x;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with cmd_valid still high.
    task automatic offer(input xfer_t x, input int max_cyc, output bit ok, output int acc_edge);
        cmd_write = x.write; cmd_addr = x.addr; cmd_wdata = x.wdata;
        cmd_strb  = x.strb;  cmd_prot = x.prot; cmd_valid = 1'b1;
        ok = 1'b0;
        acc_edge = -1;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            #4;
            if (cmd_ready) begin
                ok = 1'b1;
                acc_edge = cyc + 1;
                bus_q.push_back(x);
                exp_q.push_back(model(x));
            end
            @(negedge PCLK);
        end
        if (!ok) begin
            cmd_valid = 1'b0;
            bound_fail("cmd_accept");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge PCLK);
        if (exp_q.size() != 0) bound_fail("rsp_drain");
        repeat (2) @(negedge PCLK);
    endtask

    task automatic run_single(input xfer_t x, input int exp_lat, input string name, input bit phase_chk);
        bit ok;
        int e, lat;
        bit found;
        offer(x, 50, ok, e);
        cmd_valid = 1'b0;
        if (ok) begin
            if (phase_chk) begin
                check({name, "_setup_phase"}, {PSEL, PENABLE}, 2'b10);
                @(negedge PCLK);
                check({name, "_access_phase"}, {PSEL, PENABLE}, 2'b11);
            end
            found = 1'b0;
            for (int i = 0; i < 60; i++) begin
                if (rsp_valid) begin found = 1'b1; break; end
                @(negedge PCLK);
            end
            lat = found ? (cyc + 1 - e) : -1;
            check({name, "_latency"}, lat, exp_lat);
        end
        wait_drain();
    endtask

    // Response monitor: owns rsp_ready (except in mode 2) and pops the scoreboard on each handshake.
    initial begin : monitor
        logic [33:0] e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge PCLK);
            if (rr_mode == 0) rsp_ready = 1'b1;
            else if (rr_mode == 1) rsp_ready = ($urandom_range(0, 3) != 0);
            #4;
            if (!PRESET && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got 0x%0h with nothing outstanding",
                             {rsp_rdata, rsp_err, rsp_timeout});
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", {rsp_rdata, rsp_err, rsp_timeout}, e);
                end
            end
        end
    end

    // Reactive APB slave: wait states, data and error come from the command's descriptor.
    initial begin : slave
        xfer_t cur;
        int    acc_n;
        bit    prev_setup;
        cur = mk(1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h0);
        acc_n = 0;
        prev_setup = 1'b0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                acc_n = 0; prev_setup = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
            end else if (PSEL && PENABLE) begin
                if (acc_n == 0) begin
                    check("setup_before_access", prev_setup, 1'b1);
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_transfer: ACCESS at 0x%0h with no command outstanding", PADDR);
                        cur = mk(1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h0);
                    end else begin
                        cur = bus_q.pop_front();
                    end
                    n_xfer++;
                end
                check("paddr",  PADDR,  cur.addr);
                check("pwrite", PWRITE, cur.write);
                check("pwdata", PWDATA, cur.write ? cur.wdata : 32'h0);
                check("pstrb",  PSTRB,  cur.write ? cur.strb : 4'h0);
                check("pprot",  PPROT,  cur.prot);
                if (acc_n >= cur.waits) begin
                    PREADY = 1'b1; PRDATA = cur.write ? $urandom : cur.rdata; PSLVERR = cur.err;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
                end
                if (PREADY || acc_n == TO - 1) acc_n = 0;
                else acc_n++;
                prev_setup = 1'b0;
            end else begin
                PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
                acc_n = 0;
                prev_setup = PSEL && !PENABLE;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit ok, ok3;
        int e1, e2, e3, pop_edge, base;

        PRESET = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hDEAD_BEEF;
        cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF; cmd_prot = 3'h7;
        repeat (3) @(negedge PCLK);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        check("reset_psel_penable", {PSEL, PENABLE, PWRITE}, 3'b000);
        check("reset_paddr_pwdata", {PADDR, PWDATA}, 64'h0);
        check("reset_pstrb_pprot", {PSTRB, PPROT}, 7'h0);
        check("reset_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 35'h0);
        PRESET = 1'b0;
        cmd_valid = 1'b0;
        @(negedge PCLK);

        rr_mode = 0;
        run_single(mk(1'b1, 32'h1000, 32'hA5A5_0001, 0, 1'b0, 32'h0), 3, "write_zero_wait", 1'b1);
        run_single(mk(1'b0, 32'h2004, 32'h0, 3, 1'b0, 32'h1234_5678), 6, "read_3_waits", 1'b0);
        run_single(mk(1'b0, 32'h3000, 32'h0, 10, 1'b0, 32'h5555_AAAA), 6, "timeout", 1'b0);
        run_single(mk(1'b1, 32'h3004, 32'h0BAD_0BAD, 1, 1'b1, 32'h0), 4, "pslverr", 1'b0);

        // Back-to-back: second command rides the completion edge of the first.
        offer(mk(1'b1, 32'h4000, 32'h1111_2222, 0, 1'b0, 32'h0), 50, ok, e1);
        offer(mk(1'b0, 32'h4004, 32'h0, 0, 1'b0, 32'hCAFE_F00D), 50, ok, e2);
        cmd_valid = 1'b0;
        check("b2b_accept_spacing", e2 - e1, 2);
        wait_drain();

        // Backpressure: two transfers fill the FIFO, the third waits for a pop.
        rr_mode = 2;
        rsp_ready = 1'b0;
        base = n_xfer;
        offer(mk(1'b1, 32'h5000, 32'h0000_0001, 0, 1'b0, 32'h0), 50, ok, e1);
        offer(mk(1'b0, 32'h5004, 32'h0, 0, 1'b0, 32'h0000_0002), 50, ok, e2);
        pop_edge = -2;
        fork
            offer(mk(1'b1, 32'h5008, 32'h0000_0003, 0, 1'b0, 32'h0), 60, ok3, e3);
            begin
                repeat (20) @(negedge PCLK);
                check("bp_transfers_issued", n_xfer - base, 2);
                check("bp_cmd_ready_low", cmd_ready, 1'b0);
                rsp_ready = 1'b1;
                pop_edge = cyc + 1;
                @(negedge PCLK);
                rsp_ready = 1'b0;
            end
        join
        cmd_valid = 1'b0;
        check("bp_accept_on_pop_edge", e3, pop_edge);
        rr_mode = 0;
        @(negedge PCLK);
        offer(mk(1'b0, 32'h500C, 32'h0, 1, 1'b0, 32'h0000_0004), 60, ok, e1);
        cmd_valid = 1'b0;
        wait_drain();

        // Reset while a read is stalled in ACCESS.
        offer(mk(1'b0, 32'h6000, 32'h0, 20, 1'b0, 32'h0), 50, ok, e1);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        check("rst_mid_pre_access", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        exp_q.delete();
        bus_q.delete();
        check("rst_mid_bus_idle", {PSEL, PENABLE}, 2'b00);
        check("rst_mid_rsp_valid", rsp_valid, 1'b0);
        run_single(mk(1'b1, 32'h6004, 32'h7777_8888, 0, 1'b0, 32'h0), 3, "post_reset", 1'b0);

        // Randomized traffic with random response backpressure.
        rr_mode = 1;
        for (int i = 0; i < 150; i++) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
            offer(rand_x(), 300, ok, e1);
        end
        cmd_valid = 1'b0;
        rr_mode = 0;
        wait_drain();
        check("bus_queue_empty", bus_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Synthesizable, parametrised APB4 master that converts a valid/ready command stream into APB transfers and returns results on a buffered valid/ready response stream. It is the next generation of the team's APB master. It adds:
- configurable address/data widths,
- PSTRB/PPROT,
- back-to-back transfers without returning to IDLE,
- a PREADY timeout,
- a response FIFO, so the requester never has to wait on the bus.

It sits between a local requester (CPU shim, DMA, test sequencer) and an APB interconnect.

## Interface
- ADDR_W, 32, PADDR and cmd_addr width.
- DATA_W, 32, data width; must be 8, 16 or 32.
- RSP_DEPTH, 2, response FIFO depth; must be ≥ 2.
- TIMEOUT_CYC, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- cmd_valid / cmd_ready  in/out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid / rsp_ready  out/in  1  response handshake.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by the timeout.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB byte strobes.
- PPROT  out  3  APB protection.
- PRDATA  in  DATA_W  APB read data.
- PREADY, PSLVERR  in  1  APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0; lasts exactly 1 cycle, then ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; held until completion or timeout.
- Command acceptance:
  - cmd_fire = cmd_valid & cmd_ready.
  - done = (ACCESS & PREADY) | timeout_hit.
  - cmd_ready = (IDLE | done) & (fifo_count + done − rsp_pop < RSP_DEPTH), where rsp_pop = rsp_valid & rsp_ready.
  - This guarantees a FIFO slot exists for every accepted transfer at its completion.
- Transitions:
  - IDLE → SETUP on cmd_fire.
  - ACCESS with done and cmd_fire → SETUP: back-to-back, no IDLE cycle.
  - ACCESS with done and no cmd_fire → IDLE.
- Address-phase registers (PADDR, PWRITE, PWDATA, PSTRB, PPROT) load only on cmd_fire and are stable through SETUP and ACCESS.
  - Reads drive PSTRB = 0 and PWDATA = 0.
- On completion, push one entry {rdata, err, timeout}:
  - read: rdata = PRDATA, err = PSLVERR, timeout = 0.
  - write: rdata = 0, err = PSLVERR, timeout = 0.
- Timeout:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - timeout_hit = (TIMEOUT_CYC ≠ 0) & (count == TIMEOUT_CYC − 1) & ~PREADY.
  - On timeout_hit, push {0, 1, 1}.
  - PSEL and PENABLE drop the next cycle (or PSEL re-enters SETUP for a back-to-back command).
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Responses leave the FIFO in command order. rsp_* are the FIFO head outputs.

## Timing
- All APB outputs and cmd_ready-dependent state are registered. cmd_ready itself is combinational from state, PREADY, fifo_count and rsp_ready.
- Zero-wait read, cmd_fire at edge N:
  - SETUP in cycle N+1.
  - ACCESS in cycle N+2; PRDATA is sampled at the end of N+2.
  - rsp_valid = 1 in cycle N+3.
- Each wait state (PREADY = 0 in ACCESS) adds 1 cycle.
- Back-to-back throughput is 2 cycles per transfer, provided rsp_ready is held high.
- FIFO behaviour:
  - Full: cmd_ready = 0 until a pop frees a slot.
  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
  - Empty: rsp_valid = 0.
- Reset values (PRESET high at an edge): state = IDLE, all APB outputs 0, cmd_ready 0 during reset, FIFO flushed, rsp_valid 0, rsp_* 0, timeout counter 0.
- Reset mid-transfer: the bus drops to IDLE on the next cycle and the in-flight transfer produces no response.
- PREADY and PSLVERR are ignored outside ACCESS.

## Structure
- Package apb_pkg: apb_state_e (IDLE, SETUP, ACCESS) and PPROT bit constants (PROT_PRIV = 0, PROT_NONSEC = 1, PROT_INSTR = 2).
- Response entry width is a local parameter: DATA_W + 2.
- Sub-module apb_rsp_fifo: generic synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Outputs: count, plus first-word-fall-through head.
  - Reset: synchronous, active-high.

## Test plan
- Single write, zero wait:
  - Stimulus: cmd {write, addr 0x1000, data 0xA5A5_0001, strb 0xF}.
  - Response: PSEL rises 1 cycle after accept and PENABLE 1 cycle later; rsp {0, err 0, to 0} 3 cycles after accept.
- Read with 3 wait states:
  - Stimulus: read 0x2004, PRDATA = 0x1234_5678 on the 4th ACCESS cycle.
  - Response: rsp_rdata 0x1234_5678, rsp_err 0, total latency 6 cycles.
- Back-to-back write then read:
  - Stimulus: cmd_valid held high, rsp_ready = 1.
  - Response: no IDLE cycle between transfers (SETUP follows ACCESS directly); 2 responses in order.
- Timeout with TIMEOUT_CYC = 4:
  - Stimulus: PREADY held 0.
  - Response: ACCESS lasts exactly 4 cycles, then rsp {0, err 1, to 1}.
  - Also: PSLVERR = 1 at completion gives rsp_err 1, rsp_timeout 0.
- Backpressure with RSP_DEPTH = 2:
  - Stimulus: rsp_ready = 0 while 4 commands are offered.
  - Response: exactly 2 transfers issued and cmd_ready = 0; after popping 1 response, the 3rd is accepted the same cycle.
- Reset mid-ACCESS:
  - Stimulus: PRESET pulsed during ACCESS with PREADY = 0.
  - Response: next cycle PSEL = PENABLE = 0, rsp_valid = 0, and a following command completes normally.
